// File: rtl/txn_pkg.sv
// txn_pkg: shared definitions for the transaction arbiter slice.
//   - AwDefault / DwDefault : default address and data widths
//   - IdxW                  : width of a master index (up to four masters)
//   - txn_state_e           : shared-port sequencing states
package txn_pkg;

  localparam int unsigned AwDefault = 32;
  localparam int unsigned DwDefault = 32;
  localparam int unsigned IdxW      = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StWaitLo = 2'd2,
    StWaitHi = 2'd3
  } txn_state_e;

endpackage

// File: rtl/txn_rr_pick.sv
// txn_rr_pick: combinational winner selection.
// Returns the first pending index strictly after `last`, wrapping from NUM_M-1 to 0.
//   pending : one bit per master with a queued request
//   last    : index granted most recently
//   idx     : selected master (0 when nothing is pending)
//   valid   : at least one master is pending
module txn_rr_pick import txn_pkg::*; #(
  parameter int unsigned NUM_M = 2
) (
  input  logic [NUM_M-1:0] pending,
  input  logic [IdxW-1:0]  last,
  output logic [IdxW-1:0]  idx,
  output logic             valid
);

  logic [3:0] pend_ext;
  logic [2:0] sum;

  always_comb begin
    pend_ext = 4'(pending);
    idx      = '0;
    valid    = 1'b0;
    sum      = '0;
    // Scan from the farthest offset to the nearest so the nearest pending index wins.
    for (int off = NUM_M; off >= 1; off--) begin
      sum = {1'b0, last} + 3'(off);
      // last < NUM_M and off <= NUM_M, so a single subtraction is enough to wrap.
      if (sum >= 3'(NUM_M)) begin
        sum = sum - 3'(NUM_M);
      end
      if (pend_ext[sum[1:0]]) begin
        idx   = sum[1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/txn_arb.sv
// txn_arb: arbitrates per-master one-shot transaction requests onto a single shared port.
//
// Masters side:
//   m_req/m_wr/m_addr/m_wdata : request pulse and fields, captured only while m_rdy is high
//   m_rdata                   : registered read-return data, one DW slice per master
//   m_rdy                     : high when the master has nothing outstanding
// Shared-port side:
//   txn_req (one-cycle pulse), txn_wr, txn_addr, txn_wdata : held from issue to completion
//   txn_rdata, txn_rdy        : slave data and ready (drops for wait states)
// Status:
//   gnt_id : master currently or most recently granted
//   busy   : a transaction is in flight
//
// Build option: define TXN_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// otherwise arbitration is round-robin.
module txn_arb import txn_pkg::*; #(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned AW    = AwDefault,
  parameter int unsigned DW    = DwDefault
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_wr,
  input  logic [NUM_M*AW-1:0] m_addr,
  input  logic [NUM_M*DW-1:0] m_wdata,
  output logic [NUM_M*DW-1:0] m_rdata,
  output logic [NUM_M-1:0]    m_rdy,
  output logic              txn_req,
  output logic              txn_wr,
  output logic [AW-1:0]     txn_addr,
  output logic [DW-1:0]     txn_wdata,
  input  logic [DW-1:0]     txn_rdata,
  input  logic              txn_rdy,
  output logic [1:0]        gnt_id,
  output logic              busy
);

  txn_state_e state_q, state_d;

  logic [NUM_M-1:0]          pend_q, pend_d, cap;
  logic [NUM_M-1:0]          lat_wr_q;
  logic [NUM_M-1:0][AW-1:0]  lat_addr_q;
  logic [NUM_M-1:0][DW-1:0]  lat_wdata_q;
  logic [NUM_M*DW-1:0]       rdata_q;

  logic            req_q, wr_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [IdxW-1:0] gnt_q;

  logic [IdxW-1:0] last;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;
  logic            grant, done;

  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

`ifdef TXN_ARB_FIXED_PRIO_EN
  // Pinning the pointer at the top index makes the picker scan upward from 0.
  assign last = IdxW'(NUM_M - 1);
`else
  logic [IdxW-1:0] last_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      last_q <= IdxW'(NUM_M - 1);
    end else if (grant) begin
      last_q <= pick_idx;
    end
  end

  assign last = last_q;
`endif

  txn_rr_pick #(
    .NUM_M (NUM_M)
  ) u_pick (
    .pending (pend_q),
    .last    (last),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  // Capture is gated on the registered pending bit, so a request on the completion edge
  // of the same master is dropped.
  always_comb begin
    pend_d = pend_q;
    cap    = '0;
    for (int i = 0; i < NUM_M; i++) begin
      cap[i] = m_req[i] & ~pend_q[i];
      if (cap[i]) begin
        pend_d[i] = 1'b1;
      end else if (done && (gnt_q == IdxW'(i))) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pend_q      <= '0;
      lat_wr_q    <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < NUM_M; i++) begin
        if (cap[i]) begin
          lat_wr_q[i]    <= m_wr[i];
          lat_addr_q[i]  <= m_addr[i*AW +: AW];
          lat_wdata_q[i] <= m_wdata[i*DW +: DW];
        end
      end
    end
  end

  // Fields of the master the picker currently favours.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (pick_idx == IdxW'(i)) begin
        sel_wr    = lat_wr_q[i];
        sel_addr  = lat_addr_q[i];
        sel_wdata = lat_wdata_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid && txn_rdy) begin
          state_d = StIssue;
          grant   = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWaitLo;
      end
      StWaitLo: begin
        // Slave acknowledges the request by dropping ready.
        if (!txn_rdy) begin
          state_d = StWaitHi;
        end
      end
      StWaitHi: begin
        if (txn_rdy) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= grant;
      if (grant) begin
        wr_q    <= sel_wr;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        gnt_q   <= pick_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rdata_q <= '0;
    end else if (done && !wr_q) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (gnt_q == IdxW'(i)) begin
          rdata_q[i*DW +: DW] <= txn_rdata;
        end
      end
    end
  end

  assign m_rdy     = ~pend_q;
  assign m_rdata   = rdata_q;
  assign txn_req   = req_q;
  assign txn_wr    = wr_q;
  assign txn_addr  = addr_q;
  assign txn_wdata = wdata_q;
  assign gnt_id    = gnt_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_txn_arb.sv
// tb_txn_arb: self-checking bench for txn_arb with three masters and a one-wait-state slave.
module tb_txn_arb;

  localparam int NUM_M = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                clk    = 1'b0;
  logic                arst_n = 1'b0;
  logic [NUM_M-1:0]    m_req   = '0;
  logic [NUM_M-1:0]    m_wr    = '0;
  logic [NUM_M*AW-1:0] m_addr  = '0;
  logic [NUM_M*DW-1:0] m_wdata = '0;
  logic [NUM_M*DW-1:0] m_rdata;
  logic [NUM_M-1:0]    m_rdy;
  logic                txn_req, txn_wr;
  logic [AW-1:0]       txn_addr;
  logic [DW-1:0]       txn_wdata;
  logic [DW-1:0]       txn_rdata = '0;
  logic                txn_rdy   = 1'b1;
  logic [1:0]          gnt_id;
  logic                busy;

  txn_arb #(
    .NUM_M (NUM_M),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_rdy     (m_rdy),
    .txn_req   (txn_req),
    .txn_wr    (txn_wr),
    .txn_addr  (txn_addr),
    .txn_wdata (txn_wdata),
    .txn_rdata (txn_rdata),
    .txn_rdy   (txn_rdy),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave memory (environment) and the model's own expectation of it.
  logic [DW-1:0] sl_mem [16];
  logic [DW-1:0] md_mem [16];

  // Slave: sees the request pulse, drops ready for one cycle, then returns data.
  int            sl_cnt = 0;
  logic          sl_wr;
  logic [AW-1:0] sl_addr;
  logic [DW-1:0] sl_wdata;

  initial begin
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        sl_cnt  = 0;
        txn_rdy = 1'b1;
      end else begin
        case (sl_cnt)
          0: if (txn_req) begin
            sl_cnt = 1; sl_wr = txn_wr; sl_addr = txn_addr; sl_wdata = txn_wdata;
          end
          1: begin
            txn_rdy = 1'b0; sl_cnt = 2;
          end
          default: begin
            txn_rdy = 1'b1;
            if (sl_wr) sl_mem[sl_addr[5:2]] = sl_wdata;
            else       txn_rdata = sl_mem[sl_addr[5:2]];
            sl_cnt = 0;
          end
        endcase
      end
    end
  end

  // Transaction-level reference model.
  logic [NUM_M-1:0] md_pend;
  logic             md_wr    [NUM_M];
  logic [AW-1:0]    md_addr  [NUM_M];
  logic [DW-1:0]    md_wdata [NUM_M];
  logic [DW-1:0]    md_rdata [NUM_M];
  int               md_last, md_win, md_cnt;
  bit               md_busy;
  bit               ex_req, ex_wr;
  logic [AW-1:0]    ex_addr;
  logic [DW-1:0]    ex_wdata;
  int               ex_gnt;

  logic [NUM_M-1:0]    s_req, s_wr;
  logic [NUM_M*AW-1:0] s_addr;
  logic [NUM_M*DW-1:0] s_wdata;
  logic                s_rdy, s_rst;

  int glog[$];
  int n_pulse = 0;

  function automatic int pick(input logic [NUM_M-1:0] p, input int last);
`ifdef TXN_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NUM_M; k++) if (p[k]) return k;
`else
    for (int k = 1; k <= NUM_M; k++) if (p[(last + k) % NUM_M]) return (last + k) % NUM_M;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    md_pend = '0; md_busy = 0; md_cnt = 0; md_win = 0; md_last = NUM_M - 1;
    ex_req = 0; ex_wr = 0; ex_addr = '0; ex_wdata = '0; ex_gnt = 0;
    for (int k = 0; k < NUM_M; k++) md_rdata[k] = '0;
  endtask

  task automatic model_step();
    logic [NUM_M-1:0] prev;
    int w;
    prev   = md_pend;
    ex_req = 1'b0;
    if (md_busy) begin
      // With a one-wait-state slave a transaction completes three edges after its grant.
      md_cnt++;
      if (md_cnt == 3) begin
        md_busy = 0;
        md_pend[md_win] = 1'b0;
        if (ex_wr) md_mem[ex_addr[5:2]] = ex_wdata;
        else       md_rdata[md_win] = md_mem[ex_addr[5:2]];
      end
    end else if (prev != '0 && s_rdy) begin
      w = pick(prev, md_last);
      md_win = w; md_last = w; md_busy = 1; md_cnt = 0;
      ex_req = 1; ex_gnt = w; ex_wr = md_wr[w]; ex_addr = md_addr[w]; ex_wdata = md_wdata[w];
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (s_req[i] && !prev[i]) begin
        md_pend[i]  = 1'b1;
        md_wr[i]    = s_wr[i];
        md_addr[i]  = s_addr[i*AW +: AW];
        md_wdata[i] = s_wdata[i*DW +: DW];
      end
    end
  endtask

  task automatic model_compare();
    logic [NUM_M-1:0] exp_rdy;
    exp_rdy = ~md_pend;
    chk("m_rdy", m_rdy, exp_rdy);
    chk("busy", busy, md_busy);
    chk("txn_req", txn_req, ex_req);
    chk("gnt_id", gnt_id, ex_gnt);
    chk("txn_wr", txn_wr, ex_wr);
    chk("txn_addr", txn_addr, ex_addr);
    chk("txn_wdata", txn_wdata, ex_wdata);
    for (int i = 0; i < NUM_M; i++) chk("m_rdata", m_rdata[i*DW +: DW], md_rdata[i]);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      s_rst = arst_n; s_req = m_req; s_wr = m_wr; s_addr = m_addr; s_wdata = m_wdata;
      s_rdy = txn_rdy;
      #1;
      if (!s_rst || !arst_n) model_reset();
      else model_step();
      model_compare();
      if (txn_req) begin
        glog.push_back(int'(gnt_id));
        n_pulse++;
      end
    end
  end

  task automatic set_m(input int i, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    m_wr[i] = wr;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
  endtask

  // Pulse m_req for one capture edge; returns just after that edge.
  task automatic fire(input logic [NUM_M-1:0] mask);
    @(negedge clk);
    m_req = mask;
    @(posedge clk);
    #1;
    m_req = '0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (((m_rdy != '1) || busy) && n < bound) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, n < bound, 1);
  endtask

  task automatic latency_m0(input string tag);
    int n = 0;
    while (!m_rdy[0] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, n, 4);
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] prev_m1;
    int n, cnt1;

    for (int k = 0; k < 16; k++) begin
      v = $urandom; sl_mem[k] = v; md_mem[k] = v;
    end
    sl_mem[0] = 32'hDEAD_BEEF; md_mem[0] = 32'hDEAD_BEEF;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_rdy", m_rdy, {NUM_M{1'b1}});
    chk("rst_busy", busy, 0);
    chk("rst_txn_req", txn_req, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_txn_addr", txn_addr, 0);
    chk("rst_m_rdata", m_rdata, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Simultaneous m0/m1 pairs.
    glog.delete();
    set_m(0, 1'b0, 32'h4000_0010, '0);
    set_m(1, 1'b0, 32'h4000_0014, '0);
    fire(3'b011);
    wait_idle("pair1_idle", 40);
    fire(3'b011);
    wait_idle("pair2_idle", 40);
    chk("pair_count", glog.size(), 4);
    chk("pair1_first",  glog.size() > 0 ? glog[0] : -1, 0);
    chk("pair1_second", glog.size() > 1 ? glog[1] : -1, 1);
    chk("pair2_first",  glog.size() > 2 ? glog[2] : -1, 0);
    chk("pair2_second", glog.size() > 3 ? glog[3] : -1, 1);

    // Single m0 read: latency and return data.
    n_pulse = 0;
    set_m(0, 1'b0, 32'h4000_0000, '0);
    fire(3'b001);
    latency_m0("read_latency");
    repeat (3) @(posedge clk);
    #1;
    chk("read_pulses", n_pulse, 1);
    chk("read_data", m_rdata[31:0], 32'hDEAD_BEEF);

    // Re-pulsing m0 while it is busy must not start another transaction.
    n_pulse = 0;
    set_m(0, 1'b0, 32'h4000_0004, '0);
    fire(3'b001);
    fire(3'b001);
    fire(3'b001);
    wait_idle("repulse_idle", 40);
    repeat (5) @(posedge clk);
    #1;
    chk("repulse_pulses", n_pulse, 1);

    // m1 write: fields held while busy, m1 read-return untouched.
    prev_m1 = m_rdata[63:32];
    set_m(1, 1'b1, 32'h4000_2004, 32'h1234_5678);
    fire(3'b010);
    n = 0;
    while (!busy && n < 20) begin @(posedge clk); #1; n++; end
    chk("wr_started", n < 20, 1);
    n = 0;
    while (busy && n < 20) begin
      chk("wr_hold_wr", txn_wr, 1);
      chk("wr_hold_addr", txn_addr, 32'h4000_2004);
      chk("wr_hold_data", txn_wdata, 32'h1234_5678);
      @(posedge clk); #1; n++;
    end
    wait_idle("wr_idle", 40);
    chk("wr_m1_rdata", m_rdata[63:32], prev_m1);
    set_m(0, 1'b0, 32'h4000_2004, '0);
    fire(3'b001);
    wait_idle("rb_idle", 40);
    chk("wr_readback", m_rdata[31:0], 32'h1234_5678);

    // Reset during the final wait state abandons the transaction.
    set_m(0, 1'b0, 32'h4000_0008, '0);
    fire(3'b001);
    n = 0;
    while (!txn_req && n < 20) begin @(posedge clk); #1; n++; end
    chk("mid_rst_issue", n < 20, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_rst_busy_before", busy, 1);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_m_rdy", m_rdy, {NUM_M{1'b1}});
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_txn_req", txn_req, 0);
    chk("mid_rst_gnt", gnt_id, 0);
    chk("mid_rst_addr", txn_addr, 0);
    chk("mid_rst_rdata", m_rdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_rdata", m_rdata, 0);
    set_m(0, 1'b0, 32'h4000_0000, '0);
    fire(3'b001);
    latency_m0("post_rst_latency");
    chk("post_rst_data", m_rdata[31:0], 32'hDEAD_BEEF);

    // Continuous m0/m1 requests: grants alternate, m1 never starved.
    wait_idle("cont_pre_idle", 40);
    glog.delete();
    set_m(0, 1'b0, 32'h4000_000C, '0);
    set_m(1, 1'b0, 32'h4000_0018, '0);
    n = 0;
    while (glog.size() < 21 && n < 400) begin
      @(negedge clk); m_req = 3'b011; n++;
    end
    @(negedge clk);
    m_req = '0;
    chk("cont_rounds", glog.size() >= 21, 1);
    if (glog.size() >= 21) begin
      cnt1 = 0;
      for (int k = 0; k < 21; k++) if (glog[k] == 1) cnt1++;
      for (int k = 1; k < 21; k++) chk("cont_alternate", glog[k] != glog[k-1], 1);
      chk("cont_m1_grants", cnt1 >= 10, 1);
    end
    wait_idle("cont_idle", 40);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_M; i++) begin
        m_req[i] = ($urandom_range(0, 3) == 0);
        set_m(i, 1'($urandom_range(0, 1)), 32'h4000_0000 + 32'($urandom_range(0, 15)) * 4,
              $urandom);
      end
    end
    @(negedge clk);
    m_req = '0;
    wait_idle("rand_drain", 60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/txn_arb.md
TXN_ARB -- requirements
Module: txn_arb

Interface
REQ-001 Parameter NUM_M, default 2, number of requesting masters, legal range 2..4.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 arst_n  in  1  reset, asynchronous, active-low.
REQ-006 m_req  in  NUM_M  per-master one-cycle transaction request pulse.
REQ-007 m_wr  in  NUM_M  per-master direction: 1 write, 0 read.
REQ-008 m_addr  in  NUM_M*AW  per-master address, master i at slice [i*AW +: AW].
REQ-009 m_wdata  in  NUM_M*DW  per-master write data, master i at slice [i*DW +: DW].
REQ-010 m_rdata  out  NUM_M*DW  per-master registered read-return data.
REQ-011 m_rdy  out  NUM_M  per-master ready: 1 means idle or complete.
REQ-012 txn_req, txn_wr  out  1 each  shared-port request pulse and direction.
REQ-013 txn_addr  out  AW  shared-port address.
REQ-014 txn_wdata  out  DW  shared-port write data.
REQ-015 txn_rdata  in  DW  shared-port read data.
REQ-016 txn_rdy  in  1  shared-port ready.
REQ-017 gnt_id  out  2  index of the master currently or last granted.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 m_req[i] SHALL be captured (wr, addr, wdata latched, pending[i] set) only at an edge where m_rdy[i]=1; otherwise it is ignored.
REQ-020 m_rdy[i] SHALL equal ~pending[i]; it drops the cycle after capture.
REQ-021 FSM SHALL have states IDLE, ISSUE, WAIT_LO, WAIT_HI.
REQ-022 IDLE->ISSUE when any pending bit is set and txn_rdy=1; winner latched into gnt_id on that edge.
REQ-023 In ISSUE, txn_req SHALL be 1 for exactly one cycle with the winner's latched fields; txn_req is a registered output.
REQ-024 ISSUE->WAIT_LO unconditionally; WAIT_LO->WAIT_HI on txn_rdy=0; WAIT_HI->IDLE on txn_rdy=1.
REQ-025 On the WAIT_HI exit edge: clear pending[gnt_id]; if read, load txn_rdata into m_rdata slice gnt_id; if write, m_rdata is unchanged.
REQ-026 txn_addr, txn_wdata, txn_wr SHALL hold their values from ISSUE through WAIT_HI.
REQ-027 Arbitration is round-robin: the winner is the first pending index after last-granted, wrapping from NUM_M-1 to 0.
REQ-028 Latency with a one-wait-state slave: m_rdy[i] SHALL return high 4 edges after the edge that captured m_req[i], when uncontended.
REQ-029 A new m_req[i] on the same edge as that master's completion SHALL be ignored, because m_rdy[i] is still 0 at that edge.
REQ-030 Requests from non-granted masters arriving during WAIT_* SHALL be captured and queued as pending.

Reset
REQ-031 While arst_n=0: state=IDLE, pending=0, m_rdy all 1, m_rdata=0, txn_req=0, txn_wr=0, txn_addr=0, txn_wdata=0, gnt_id=0, busy=0, last-granted=NUM_M-1.
REQ-032 Reset mid-transaction SHALL abandon that transaction with no completion and no m_rdata update.

Configuration
REQ-033 With macro TXN_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest pending index wins), and the last-granted register is omitted.
REQ-034 Without TXN_ARB_FIXED_PRIO_EN, round-robin per REQ-027 applies.

Structure
REQ-035 Shared package txn_pkg SHALL hold the FSM state encoding and the AW/DW default constants.
REQ-036 Winner selection SHALL be a combinational sub-module txn_rr_pick (inputs: pending, last-granted; output: index and valid).

Verification
REQ-037 Reset, then m0 read at addr 0x40000000 with mem[0]=0xDEADBEEF -> txn_req single pulse; m_rdy[0] high 4 edges after capture; m_rdata[31:0]=0xDEADBEEF.
REQ-038 m0 and m1 req on the same edge -> m0 served first, then m1; next simultaneous pair -> m0 again (RR); with TXN_ARB_FIXED_PRIO_EN, m0 always first.
REQ-039 m1 write addr 0x40002004, data 0x12345678 -> txn_wr=1 with that addr/data held until completion; m_rdata[63:32] unchanged.
REQ-040 m0 re-pulses m_req while m_rdy[0]=0 -> no second transaction; exactly one txn_req pulse observed.
REQ-041 Assert arst_n=0 during WAIT_HI -> all outputs at reset values immediately; after release, a new m0 read completes normally.
REQ-042 m1 requests continuously while m0 is active -> m1 gets the next grant after m0 completes; no starvation over 10 rounds.
